// File: rtl/band_envelope_accumulator.sv
// rtl/band_envelope_accumulator.sv - per-band |x| accumulation over a frame window with a single-entry output buffer
// One window close produces one envelope vector; a full, stalled buffer drops the newer result and flags overrun.
module band_envelope_accumulator #(
   parameter  int NBANDS    = 16,
   parameter  int IN_W      = 35,
   parameter  int WINDOW    = 64,
   parameter  int OUT_SHIFT = 17,
   parameter  int OUT_W     = 24,
   localparam int CNT_W     = $clog2(WINDOW)
) (
   input  logic                    clk_en,
   input  logic                    reset,
   input  logic                    in_en,
   input  logic [NBANDS*IN_W-1:0]  band_in,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [NBANDS*OUT_W-1:0] out_data,
   output logic [CNT_W-1:0]        win_cnt,
   output logic                    overrun
);

   localparam int MAG_W  = IN_W - 1;
   localparam int ACC_W  = MAG_W + CNT_W;
   localparam int WIDE_W = ACC_W + OUT_W;

   typedef enum logic {EMPTY, FULL} state_t;
   state_t state, state_nxt;

   logic [IN_W-1:0]          x_val   [NBANDS];
   logic [IN_W-1:0]          x_neg   [NBANDS];
   logic [MAG_W-1:0]         mag     [NBANDS];
   logic [ACC_W-1:0]         acc     [NBANDS];
   logic [ACC_W-1:0]         sum     [NBANDS];
   logic [WIDE_W-1:0]        shifted [NBANDS];
   logic [NBANDS*OUT_W-1:0]  result;
   logic                     close;
   logic                     load;
   logic                     set_ovr;

   assign close     = in_en && (win_cnt == CNT_W'(WINDOW - 1));
   assign out_valid = (state == FULL);

   // Negating the most negative input overflows back to itself; clamp it to the largest magnitude.
   always_comb begin
      result = '0;
      for (int b = 0; b < NBANDS; b++) begin
         x_val[b] = band_in[b*IN_W +: IN_W];
         x_neg[b] = ~x_val[b] + IN_W'(1);
         if (!x_val[b][IN_W-1])
            mag[b] = x_val[b][IN_W-2:0];
         else if (x_neg[b][IN_W-1])
            mag[b] = {MAG_W{1'b1}};
         else
            mag[b] = x_neg[b][IN_W-2:0];
         sum[b]     = acc[b] + ACC_W'(mag[b]);
         shifted[b] = WIDE_W'(sum[b] >> OUT_SHIFT);
         if (shifted[b] > WIDE_W'({OUT_W{1'b1}}))
            result[b*OUT_W +: OUT_W] = {OUT_W{1'b1}};
         else
            result[b*OUT_W +: OUT_W] = shifted[b][OUT_W-1:0];
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      set_ovr   = 1'b0;
      case (state)
         EMPTY: begin
            if (close) begin
               load      = 1'b1;
               state_nxt = FULL;
            end
         end
         FULL: begin
            if (close) begin
               if (out_ready) load    = 1'b1;
               else           set_ovr = 1'b1;
            end else if (out_ready) begin
               state_nxt = EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk_en) begin
      if (reset) begin
         state    <= EMPTY;
         out_data <= '0;
         win_cnt  <= '0;
         overrun  <= 1'b0;
         for (int b = 0; b < NBANDS; b++) acc[b] <= '0;
      end else begin
         state <= state_nxt;
         if (load)    out_data <= result;
         if (set_ovr) overrun  <= 1'b1;
         // WINDOW is a power of two, so the counter wraps to zero on the closing frame.
         if (in_en) begin
            win_cnt <= win_cnt + CNT_W'(1);
            for (int b = 0; b < NBANDS; b++) acc[b] <= close ? '0 : sum[b];
         end
      end
   end

endmodule

// File: tb/tb_band_envelope_accumulator.sv
// tb/tb_band_envelope_accumulator.sv - self-checking bench for band_envelope_accumulator
// Small-window instance runs vector tables; default instance runs directed frames and a random model comparison.
module tb_band_envelope_accumulator;

   localparam int     NB     = 16;
   localparam int     IW     = 35;
   localparam longint MINV   = -64'sd17179869184;
   localparam longint MAGMAX = 64'sd17179869183;

   logic             clk_en = 1'b0;
   logic             reset  = 1'b1;

   logic             b_in_en = 1'b0;
   logic [NB*IW-1:0] b_band  = '0;
   logic             b_ready = 1'b0;
   logic             b_valid;
   logic [NB*24-1:0] b_data;
   logic [5:0]       b_cnt;
   logic             b_ovr;

   logic             s_in_en = 1'b0;
   logic [NB*IW-1:0] s_band  = '0;
   logic             s_ready = 1'b0;
   logic             s_valid;
   logic [NB*8-1:0]  s_data;
   logic [1:0]       s_cnt;
   logic             s_ovr;

   band_envelope_accumulator dut_big (
      .clk_en(clk_en), .reset(reset), .in_en(b_in_en), .band_in(b_band), .out_ready(b_ready),
      .out_valid(b_valid), .out_data(b_data), .win_cnt(b_cnt), .overrun(b_ovr)
   );

   band_envelope_accumulator #(.WINDOW(4), .OUT_SHIFT(0), .OUT_W(8)) dut_small (
      .clk_en(clk_en), .reset(reset), .in_en(s_in_en), .band_in(s_band), .out_ready(s_ready),
      .out_valid(s_valid), .out_data(s_data), .win_cnt(s_cnt), .overrun(s_ovr)
   );

   always #5 clk_en = ~clk_en;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [NB*24-1:0] act, input logic [NB*24-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_en);
      #1;
   endtask

   // Reference model: a window sum per band and a one-slot mailbox for the result.
   longint           cur_x [NB];
   longint           m_acc [NB];
   int               m_cnt;
   bit               m_valid;
   bit               m_ovr;
   logic [NB*24-1:0] m_data;

   function automatic longint mag_of(input longint x);
      if (x >= 0)    return x;
      if (x == MINV) return MAGMAX;
      return -x;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < NB; b++) m_acc[b] = 0;
      m_cnt = 0; m_valid = 0; m_ovr = 0; m_data = '0;
   endtask

   task automatic model_step(input bit en, input bit rdy);
      bit closing;
      closing = en && (m_cnt == 63);
      if (m_valid && rdy) m_valid = 0;
      if (closing) begin
         if (!m_valid) begin
            for (int b = 0; b < NB; b++) begin
               longint s;
               s = (m_acc[b] + mag_of(cur_x[b])) / 131072;
               if (s > 16777215) s = 16777215;
               m_data[b*24 +: 24] = s[23:0];
            end
            m_valid = 1;
         end else begin
            m_ovr = 1;
         end
      end
      if (en) begin
         for (int b = 0; b < NB; b++) m_acc[b] = closing ? 0 : m_acc[b] + mag_of(cur_x[b]);
         m_cnt = closing ? 0 : m_cnt + 1;
      end
   endtask

   task automatic set_big_all(input longint x);
      for (int b = 0; b < NB; b++) begin
         cur_x[b] = x;
         b_band[b*IW +: IW] = x[IW-1:0];
      end
   endtask

   typedef struct {
      bit     en;
      longint x;
      bit     rdy;
      bit     v;
      int     c;
      int     o;
      bit     ov;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [NB*24-1:0] exp_vec;
      logic signed [IW-1:0] rv;
      longint xv;
      int frames;

      // window 4, shift 0, 8-bit output; only band 0 is non-zero
      tbl.push_back('{1, 10,   1, 0, 1, 0,   0});
      tbl.push_back('{1, -20,  1, 0, 2, 0,   0});
      tbl.push_back('{1, 30,   1, 0, 3, 0,   0});
      tbl.push_back('{1, -40,  1, 1, 0, 100, 0});
      tbl.push_back('{0, 0,    1, 0, 0, 100, 0});
      tbl.push_back('{1, MINV, 1, 0, 1, 100, 0});
      tbl.push_back('{1, MINV, 1, 0, 2, 100, 0});
      tbl.push_back('{1, MINV, 1, 0, 3, 100, 0});
      tbl.push_back('{1, MINV, 1, 1, 0, 255, 0});
      tbl.push_back('{0, 0,    1, 0, 0, 255, 0});
      tbl.push_back('{1, 5,    0, 0, 1, 255, 0});
      tbl.push_back('{1, -5,   0, 0, 2, 255, 0});
      tbl.push_back('{1, 5,    0, 0, 3, 255, 0});
      tbl.push_back('{1, -5,   0, 1, 0, 20,  0});
      tbl.push_back('{1, 7,    0, 1, 1, 20,  0});
      tbl.push_back('{1, 7,    0, 1, 2, 20,  0});
      tbl.push_back('{1, 7,    0, 1, 3, 20,  0});
      tbl.push_back('{1, 7,    0, 1, 0, 20,  1});
      tbl.push_back('{0, 0,    0, 1, 0, 20,  1});
      tbl.push_back('{0, 0,    1, 0, 0, 20,  1});
      tbl.push_back('{0, 0,    1, 0, 0, 20,  1});

      // reset state of both instances
      tick(); tick();
      reset = 1'b0;
      chk("rst_big_valid", b_valid, 0);
      chk("rst_big_cnt",   b_cnt,   0);
      chk("rst_big_ovr",   b_ovr,   0);
      chk_vec("rst_big_data", b_data, '0);
      chk("rst_small_valid", s_valid, 0);
      chk("rst_small_cnt",   s_cnt,   0);
      chk("rst_small_ovr",   s_ovr,   0);
      chk("rst_small_data",  s_data,  0);

      // 64 frames of +1000 on every band
      b_ready = 1'b1;
      b_in_en = 1'b1;
      set_big_all(1000);
      for (int i = 1; i <= 64; i++) begin
         tick();
         chk($sformatf("w64_valid_%0d", i), b_valid, (i == 64) ? 1 : 0);
         chk($sformatf("w64_cnt_%0d", i), b_cnt, i % 64);
      end
      chk_vec("w64_data", b_data, '0);
      chk("w64_ovr", b_ovr, 0);
      b_in_en = 1'b0;
      tick();
      chk("w64_drain", b_valid, 0);

      // table vectors on the small instance
      for (int i = 0; i < tbl.size(); i++) begin
         xv = tbl[i].x;
         s_in_en = tbl[i].en;
         s_ready = tbl[i].rdy;
         s_band = '0;
         s_band[IW-1:0] = xv[IW-1:0];
         tick();
         chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].v);
         chk($sformatf("tbl%0d_cnt", i), s_cnt, tbl[i].c);
         chk($sformatf("tbl%0d_out0", i), s_data[7:0], tbl[i].o);
         chk($sformatf("tbl%0d_ovr", i), s_ovr, tbl[i].ov);
      end

      // close while FULL with ready on the same edge: new result, no bubble
      s_in_en = 1'b0; s_ready = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      chk("nb_rst_ovr", s_ovr, 0);
      s_in_en = 1'b1;
      s_band = '0; s_band[IW-1:0] = 35'd3;
      for (int i = 0; i < 4; i++) tick();
      chk("nb_first_valid", s_valid, 1);
      chk("nb_first_out", s_data[7:0], 12);
      s_band[IW-1:0] = 35'd2;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("nb_hold_valid_%0d", i), s_valid, 1);
         chk($sformatf("nb_hold_out_%0d", i), s_data[7:0], 12);
      end
      s_ready = 1'b1;
      tick();
      chk("nb_valid", s_valid, 1);
      chk("nb_out", s_data[7:0], 8);
      chk("nb_ovr", s_ovr, 0);
      s_in_en = 1'b0;
      tick();
      chk("nb_drain", s_valid, 0);
      s_ready = 1'b0;

      // reset mid-window with gaps: pre-reset frames must not leak into the next window
      b_ready = 1'b1;
      set_big_all(64'sd4194304);
      frames = 0;
      for (int i = 0; frames < 30; i++) begin
         b_in_en = (i % 3 != 2);
         if (b_in_en) frames++;
         tick();
      end
      chk("mid_cnt_before", b_cnt, 30);
      b_in_en = 1'b1;
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mid_rst_cnt", b_cnt, 0);
      chk("mid_rst_valid", b_valid, 0);
      model_reset();
      set_big_all(64'sd1048576);
      frames = 0;
      for (int i = 0; frames < 64; i++) begin
         b_in_en = (i % 4 != 3);
         if (b_in_en) frames++;
         model_step(b_in_en, b_ready);
         tick();
      end
      for (int b = 0; b < NB; b++) exp_vec[b*24 +: 24] = 24'd512;
      chk("mid_valid", b_valid, 1);
      chk_vec("mid_data", b_data, exp_vec);

      // random frames against the model; a long ready-low stretch provokes overrun
      for (int i = 0; i < 600; i++) begin
         b_in_en = ($urandom_range(0, 3) != 0);
         b_ready = ((i / 150) % 2 == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         for (int b = 0; b < NB; b++) begin
            rv = IW'({$urandom(), $urandom()});
            if ($urandom_range(0, 15) == 0) rv = {1'b1, {(IW-1){1'b0}}};
            cur_x[b] = longint'(rv);
            b_band[b*IW +: IW] = rv;
         end
         model_step(b_in_en, b_ready);
         tick();
         chk($sformatf("rnd%0d_valid", i), b_valid, m_valid);
         chk($sformatf("rnd%0d_cnt", i), b_cnt, m_cnt);
         chk($sformatf("rnd%0d_ovr", i), b_ovr, m_ovr);
         chk_vec($sformatf("rnd%0d_data", i), b_data, m_data);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
